accel_host_link: RTL and testbench
==================================

ACCEL_HOST_LINK -- requirements
Module: accel_host_link

Interface
REQ-001 SHALL have parameter W, default 16, accelerator data word width.
REQ-002 SHALL have parameter AL, default 11, command length field width (matches neuron/kernel buffer address width).
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from READ instruction to valid accelerator dataOut; legal 1..3.
REQ-004 SHALL have ports:
- CLK  in  1  single clock, rising edge
- RSTn  in  1  asynchronous active-low reset
- cmdValid  in  1  command offered
- cmdReady  out  1  command accepted when cmdValid&cmdReady
- cmdOp  in  2  01 LOAD, 10 RUN, 11 UNLOAD, 00 reserved
- cmdLen  in  AL  word count (LOAD/UNLOAD) or wait cycles (RUN)
- wrData  in  W  host write word
- wrValid  in  1  write word offered
- wrReady  out  1  write word accepted when wrValid&wrReady
- rdData  out  W  result word
- rdValid  out  1  result word available
- rdReady  in  1  host takes result when rdValid&rdReady
- busy  out  1  high whenever state is not IDLE
- accDataIn  out  W  to accelerator dataIn
- accInstr  out  2  to accelerator instruction: 00 NOP, 01 WRITE, 10 START, 11 READ
- accDataOut  in  W  from accelerator dataOut

Function
REQ-005 SHALL implement states IDLE, LOAD, RUN, UNLOAD, DRAIN; all outputs registered.
REQ-006 IDLE: cmdReady=1; on handshake latch cmdOp/cmdLen into remaining counter; go LOAD/RUN/UNLOAD; op 00 accepted and ignored (stay IDLE); cmdLen=0 accepted, returns to IDLE next cycle with no accelerator traffic.
REQ-007 LOAD: wrReady=1; each wrValid&wrReady drives accInstr=01, accDataIn=wrData next cycle; else accInstr=00; decrement counter per word; after final word go IDLE.
REQ-008 RUN: first cycle drive accInstr=10 exactly once, then 00 for cmdLen further cycles, then IDLE.
REQ-009 UNLOAD: issue accInstr=11 only when credits>0; credits = 4 − (buffered + in-flight reads); capture accDataOut exactly RD_LAT cycles after each READ into 4-entry result FIFO.
REQ-010 After last READ issued go DRAIN; leave DRAIN to IDLE when in-flight=0 (FIFO may still hold data).
REQ-011 rdData/rdValid SHALL reflect FIFO head; FIFO never overflows; results delivered in READ order without loss or duplication under arbitrary rdReady.
REQ-012 Simultaneous FIFO push and pop SHALL preserve occupancy.
REQ-013 cmdReady SHALL be 0 in all non-IDLE states; a new UNLOAD may start while FIFO is non-empty, credits account for it.
REQ-014 accDataIn SHALL hold last written value when accInstr≠01.
REQ-015 Counters SHALL be AL bits; no wrap: counter stops at 0.

Reset
REQ-016 RSTn low SHALL immediately force: state IDLE, accInstr=00, accDataIn=0, rdValid=0, rdData=0, FIFO empty, credits=4, counters 0, in-flight pipeline cleared, busy=0, wrReady=0, cmdReady=0.
REQ-017 cmdReady SHALL rise the first cycle after RSTn deasserts; reset mid-operation abandons the command with no further accelerator instructions.

Configuration
REQ-018 Macro ACCEL_HOST_LINK_STATS_EN defined: add outputs statWordsIn[31:0] and statWordsOut[31:0] counting WRITE and READ instructions issued, reset to 0, saturating at all-ones; undefined: ports absent, no counters.

Verification
REQ-019 LOAD cmdLen=3, words 0x1111,0x2222,0x3333 continuous -> accInstr 01 three consecutive cycles, accDataIn matches order, then IDLE, cmdReady=1.
REQ-020 RUN cmdLen=5 -> accInstr 10 one cycle then 00 five cycles, busy high 6 cycles total.
REQ-021 UNLOAD cmdLen=6, accelerator model returns 0xA0+n at RD_LAT=2, rdReady held 0 -> exactly 4 READs issued, rdValid=1 with 0xA0; release rdReady -> all six values 0xA0..0xA5 in order.
REQ-022 UNLOAD cmdLen=8, rdReady toggling 1/0 each cycle, RD_LAT=3 -> eight results in order, no FIFO overflow, DRAIN exits only after last capture.
REQ-023 RSTn low mid-LOAD after 2 of 4 words -> accInstr=00 immediately, FIFO empty, cmdReady=1 one cycle after release.
REQ-024 With ACCEL_HOST_LINK_STATS_EN: LOAD 3 + UNLOAD 2 -> statWordsIn=3, statWordsOut=2; cmdLen=0 LOAD -> counters unchanged.

Source files
------------

// File: rtl/accel_host_link_if.sv
// Host-side command/write/read channels and the accelerator-side port bundle
// of accel_host_link. The slave modport is the link itself; the master
// modport is its environment (host plus accelerator).
interface accel_host_link_if #(
    parameter int W  = 16,
    parameter int AL = 11
);
    logic          cmdValid;
    logic          cmdReady;
    logic [1:0]    cmdOp;
    logic [AL-1:0] cmdLen;
    logic [W-1:0]  wrData;
    logic          wrValid;
    logic          wrReady;
    logic [W-1:0]  rdData;
    logic          rdValid;
    logic          rdReady;
    logic          busy;
    logic [W-1:0]  accDataIn;
    logic [1:0]    accInstr;
    logic [W-1:0]  accDataOut;

    modport master (
        output cmdValid, cmdOp, cmdLen, wrData, wrValid, rdReady, accDataOut,
        input  cmdReady, wrReady, rdData, rdValid, busy, accDataIn, accInstr
    );

    modport slave (
        input  cmdValid, cmdOp, cmdLen, wrData, wrValid, rdReady, accDataOut,
        output cmdReady, wrReady, rdData, rdValid, busy, accDataIn, accInstr
    );
endinterface

// File: rtl/accel_host_link.sv
// Host link for a word-serial accelerator: loads words (WRITE), starts a run
// (START) and unloads results (READ) into a 4-entry result FIFO. READs are
// credit-limited so every result always has a FIFO slot reserved.
// Optional build macro ACCEL_HOST_LINK_STATS_EN adds saturating counters of
// issued WRITE and READ instructions.
module accel_host_link #(
    parameter int W      = 16,
    parameter int AL     = 11,
    parameter int RD_LAT = 2     // legal 1..3
) (
    input  logic               CLK,
    input  logic               RSTn,
    accel_host_link_if.slave   bus
`ifdef ACCEL_HOST_LINK_STATS_EN
    ,
    output logic [31:0]        statWordsIn,
    output logic [31:0]        statWordsOut
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_UNLOAD, S_DRAIN} state_e;

    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;
    localparam logic [1:0] OP_UNLOAD = 2'b11;

    localparam logic [1:0] I_NOP   = 2'b00;
    localparam logic [1:0] I_WRITE = 2'b01;
    localparam logic [1:0] I_START = 2'b10;
    localparam logic [1:0] I_READ  = 2'b11;

    state_e        state_q;
    logic [AL-1:0] cnt_q;
    logic          cmd_ready_q, wr_ready_q, busy_q;
    logic [1:0]    acc_instr_q;
    logic [W-1:0]  acc_data_in_q;

    // Bit i set: a READ was on accInstr i cycles ago; bit RD_LAT marks capture.
    logic [RD_LAT:0] rd_pipe_q;
    logic [W-1:0]    fifo_q [4];
    logic [W-1:0]    fifo_d [4];
    logic [2:0]      fifo_cnt_q, fifo_cnt_d;
    logic            rd_valid_q;

    logic [2:0] inflight;
    logic [3:0] credits;
    logic       issue_wr, issue_rd, push, pop;

    // Count READs still travelling through the accelerator and derive credits.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + 3'(rd_pipe_q[i]);
        end
        credits = 4'd4 - ({1'b0, fifo_cnt_q} + {1'b0, inflight});
    end

    assign issue_wr = (state_q == S_LOAD) && wr_ready_q && bus.wrValid;
    assign issue_rd = (state_q == S_UNLOAD) && (cnt_q != '0) && (credits != 4'd0);
    assign push     = rd_pipe_q[RD_LAT];
    assign pop      = rd_valid_q && bus.rdReady;

    // Command FSM with registered handshake and accelerator outputs.
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            wr_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            acc_instr_q   <= I_NOP;
            acc_data_in_q <= '0;
        end else begin
            acc_instr_q <= I_NOP;
            unique case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    // Zero length and reserved op are accepted but start nothing.
                    if (bus.cmdValid && cmd_ready_q && bus.cmdLen != '0) begin
                        unique case (bus.cmdOp)
                            OP_LOAD: begin
                                state_q     <= S_LOAD;
                                cnt_q       <= bus.cmdLen;
                                cmd_ready_q <= 1'b0;
                                wr_ready_q  <= 1'b1;
                                busy_q      <= 1'b1;
                            end
                            OP_RUN: begin
                                state_q     <= S_RUN;
                                cnt_q       <= bus.cmdLen;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                                acc_instr_q <= I_START;
                            end
                            OP_UNLOAD: begin
                                state_q     <= S_UNLOAD;
                                cnt_q       <= bus.cmdLen;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (issue_wr) begin
                        acc_instr_q   <= I_WRITE;
                        acc_data_in_q <= bus.wrData;
                        if (cnt_q != '0) cnt_q <= cnt_q - AL'(1);
                        if (cnt_q <= AL'(1)) begin
                            state_q     <= S_IDLE;
                            wr_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - AL'(1);
                    end
                end
                S_UNLOAD: begin
                    if (issue_rd) begin
                        acc_instr_q <= I_READ;
                        cnt_q       <= cnt_q - AL'(1);
                        if (cnt_q == AL'(1)) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (inflight == 3'd0) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Result FIFO next state: shift-down on pop, then write behind the last entry.
    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        fifo_d     = fifo_q;
        fifo_cnt_d = fifo_cnt_q;
        if (pop) begin
            for (int i = 0; i < 3; i++) fifo_d[i] = fifo_q[i+1];
            fifo_d[3]  = '0;
            fifo_cnt_d = fifo_cnt_q - 3'd1;
        end
        if (push) begin
            fifo_d[fifo_cnt_d[1:0]] = bus.accDataOut;
            fifo_cnt_d              = fifo_cnt_d + 3'd1;
        end
    end

    // READ latency pipeline and result FIFO storage.
    // NOTE: the four FIFO words are reset because entry 0 drives rdData,
    // which must read 0 out of reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_pipe_q  <= '0;
            fifo_q     <= '{default: '0};
            fifo_cnt_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_pipe_q  <= {rd_pipe_q[RD_LAT-1:0], issue_rd};
            fifo_q     <= fifo_d;
            fifo_cnt_q <= fifo_cnt_d;
            rd_valid_q <= (fifo_cnt_d != 3'd0);
        end
    end

`ifdef ACCEL_HOST_LINK_STATS_EN
    logic [31:0] stat_in_q, stat_out_q;

    // Saturating counts of WRITE and READ instructions issued.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stat_in_q  <= '0;
            stat_out_q <= '0;
        end else begin
            if (issue_wr && stat_in_q != '1)  stat_in_q  <= stat_in_q + 32'd1;
            if (issue_rd && stat_out_q != '1) stat_out_q <= stat_out_q + 32'd1;
        end
    end

    assign statWordsIn  = stat_in_q;
    assign statWordsOut = stat_out_q;
`endif

    assign bus.cmdReady  = cmd_ready_q;
    assign bus.wrReady   = wr_ready_q;
    assign bus.busy      = busy_q;
    assign bus.accInstr  = acc_instr_q;
    assign bus.accDataIn = acc_data_in_q;
    assign bus.rdData    = fifo_q[0];
    assign bus.rdValid   = rd_valid_q;
endmodule

// File: tb/tb_accel_host_link.sv
// Directed bench for accel_host_link: two instances (RD_LAT 2 and 3) share
// the host stimulus; each has its own accelerator model and result queue.
module tb_accel_host_link;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [10:0] cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        rd_ready;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    accel_host_link_if #(.W(16), .AL(11)) bus2 ();
    accel_host_link_if #(.W(16), .AL(11)) bus3 ();

    assign bus2.cmdValid = cmd_valid;
    assign bus2.cmdOp    = cmd_op;
    assign bus2.cmdLen   = cmd_len;
    assign bus2.wrData   = wr_data;
    assign bus2.wrValid  = wr_valid;
    assign bus2.rdReady  = rd_ready;
    assign bus3.cmdValid = cmd_valid;
    assign bus3.cmdOp    = cmd_op;
    assign bus3.cmdLen   = cmd_len;
    assign bus3.wrData   = wr_data;
    assign bus3.wrValid  = wr_valid;
    assign bus3.rdReady  = rd_ready;

`ifdef ACCEL_HOST_LINK_STATS_EN
    logic [31:0] st_in2, st_out2, st_in3, st_out3;
`endif

    accel_host_link #(.W(16), .AL(11), .RD_LAT(2)) dut2 (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus2)
`ifdef ACCEL_HOST_LINK_STATS_EN
        ,
        .statWordsIn  (st_in2),
        .statWordsOut (st_out2)
`endif
    );

    accel_host_link #(.W(16), .AL(11), .RD_LAT(3)) dut3 (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus3)
`ifdef ACCEL_HOST_LINK_STATS_EN
        ,
        .statWordsIn  (st_in3),
        .statWordsOut (st_out3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accelerator models: the n-th READ returns 0xA0+n, valid exactly RD_LAT
    // cycles after the READ cycle; other cycles carry a junk value.
    logic [15:0] st2 [1:3];
    logic [15:0] st3 [1:3];
    logic [3:1]  v2 = '0;
    logic [3:1]  v3 = '0;
    int          n2 = 0;
    int          n3 = 0;

    always @(posedge clk) begin
        st2[1] <= (bus2.accInstr == 2'b11) ? 16'(16'hA0 + n2) : 16'hDEAD;
        v2[1]  <= (bus2.accInstr == 2'b11);
        if (bus2.accInstr == 2'b11) n2 <= n2 + 1;
        st2[2] <= st2[1];
        st2[3] <= st2[2];
        v2[3:2] <= v2[2:1];
    end

    always @(posedge clk) begin
        st3[1] <= (bus3.accInstr == 2'b11) ? 16'(16'hA0 + n3) : 16'hDEAD;
        v3[1]  <= (bus3.accInstr == 2'b11);
        if (bus3.accInstr == 2'b11) n3 <= n3 + 1;
        st3[2] <= st3[1];
        st3[3] <= st3[2];
        v3[3:2] <= v3[2:1];
    end

    assign bus2.accDataOut = st2[2];
    assign bus3.accDataOut = st3[3];

    // Scoreboard and per-cycle bookkeeping.
    logic [15:0] q2[$];
    logic [15:0] q3[$];
    int          rd_k   = 0;
    int          reads2 = 0;
    int          reads3 = 0;
    logic        pb2    = 1'b0;
    logic        pb3    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [31:0] o2, input logic [31:0] o3,
                          input logic [31:0] exp);
        check({tag, "@lat2"}, o2, exp);
        check({tag, "@lat3"}, o3, exp);
    endtask

    task automatic push_expected(input int len);
        for (int i = 0; i < len; i++) begin
            q2.push_back(16'(16'hA0 + rd_k));
            q3.push_back(16'(16'hA0 + rd_k));
            rd_k++;
        end
    endtask

    // Runs at mid-cycle with this cycle's inputs already driven.
    task automatic monitor();
        logic [31:0] exp;
        if (bus2.accInstr == 2'b11) reads2++;
        if (bus3.accInstr == 2'b11) reads3++;
        if (bus2.rdValid && rd_ready) begin
            exp = (q2.size() != 0) ? 32'(q2.pop_front()) : 32'hDEAD_BEEF;
            check("result@lat2", bus2.rdData, exp);
        end
        if (bus3.rdValid && rd_ready) begin
            exp = (q3.size() != 0) ? 32'(q3.pop_front()) : 32'hDEAD_BEEF;
            check("result@lat3", bus3.rdData, exp);
        end
        if (pb2 && !bus2.busy) check("idle_with_reads_pending@lat2", 32'(|v2[2:1]), 0);
        if (pb3 && !bus3.busy) check("idle_with_reads_pending@lat3", 32'(|v3[3:1]), 0);
        pb2 = bus2.busy;
        pb3 = bus3.busy;
    endtask

    task automatic cyc();
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [10:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (bus2.busy || bus3.busy); i++) cyc();
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        #1 rst_n  = 1'b0;
        @(negedge clk);

        // Reset state.
        check2("rst_cmdReady", bus2.cmdReady, bus3.cmdReady, 0);
        check2("rst_busy",     bus2.busy,     bus3.busy,     0);
        check2("rst_wrReady",  bus2.wrReady,  bus3.wrReady,  0);
        check2("rst_accInstr", bus2.accInstr, bus3.accInstr, 0);
        check2("rst_accDataIn", bus2.accDataIn, bus3.accDataIn, 0);
        check2("rst_rdValid",  bus2.rdValid,  bus3.rdValid,  0);
        check2("rst_rdData",   bus2.rdData,   bus3.rdData,   0);
        rst_n = 1'b1;
        check2("cmdReady_before_edge", bus2.cmdReady, bus3.cmdReady, 0);
        cyc();
        check2("cmdReady_after_release", bus2.cmdReady, bus3.cmdReady, 1);

        // LOAD of three back-to-back words.
        send_cmd(2'b01, 11'd3);
        check2("load_wrReady",  bus2.wrReady,  bus3.wrReady,  1);
        check2("load_cmdReady", bus2.cmdReady, bus3.cmdReady, 0);
        check2("load_busy",     bus2.busy,     bus3.busy,     1);
        wr_valid = 1'b1;
        wr_data  = 16'h1111;
        cyc();
        check2("load_w0_instr", bus2.accInstr,  bus3.accInstr,  1);
        check2("load_w0_data",  bus2.accDataIn, bus3.accDataIn, 16'h1111);
        wr_data = 16'h2222;
        cyc();
        check2("load_w1_instr", bus2.accInstr,  bus3.accInstr,  1);
        check2("load_w1_data",  bus2.accDataIn, bus3.accDataIn, 16'h2222);
        wr_data = 16'h3333;
        cyc();
        check2("load_w2_instr", bus2.accInstr,  bus3.accInstr,  1);
        check2("load_w2_data",  bus2.accDataIn, bus3.accDataIn, 16'h3333);
        check2("load_done_cmdReady", bus2.cmdReady, bus3.cmdReady, 1);
        check2("load_done_wrReady",  bus2.wrReady,  bus3.wrReady,  0);
        check2("load_done_busy",     bus2.busy,     bus3.busy,     0);
        wr_valid = 1'b0;
        wr_data  = 16'h7777;
        cyc();
        check2("post_load_nop",  bus2.accInstr,  bus3.accInstr,  0);
        check2("post_load_hold", bus2.accDataIn, bus3.accDataIn, 16'h3333);
`ifdef ACCEL_HOST_LINK_STATS_EN
        check2("stat_in_after_load", st_in2, st_in3, 3);
        check2("stat_out_after_load", st_out2, st_out3, 0);
`endif

        // RUN with five wait cycles: START once, then five NOP cycles, busy 6.
        send_cmd(2'b10, 11'd5);
        check2("run_start", bus2.accInstr, bus3.accInstr, 2);
        check2("run_busy0", bus2.busy,     bus3.busy,     1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check2($sformatf("run_wait%0d_instr", i), bus2.accInstr, bus3.accInstr, 0);
            check2($sformatf("run_wait%0d_busy", i),  bus2.busy,     bus3.busy,     1);
        end
        cyc();
        check2("run_end_busy",     bus2.busy,     bus3.busy,     0);
        check2("run_end_cmdReady", bus2.cmdReady, bus3.cmdReady, 1);

        // UNLOAD 6 with the host stalled: only four READs fit the credits.
        reads2 = 0;
        reads3 = 0;
        rd_ready = 1'b0;
        push_expected(6);
        send_cmd(2'b11, 11'd6);
        for (int i = 0; i < 12; i++) cyc();
        check("stalled_reads@lat2", reads2, 4);
        check("stalled_reads@lat3", reads3, 4);
        check2("stalled_rdValid", bus2.rdValid, bus3.rdValid, 1);
        check2("stalled_head",    bus2.rdData,  bus3.rdData,  16'hA0);
        check2("stalled_busy",    bus2.busy,    bus3.busy,    1);
        rd_ready = 1'b1;
        for (int i = 0; i < 60 && (q2.size() != 0 || q3.size() != 0 || bus2.busy || bus3.busy); i++) cyc();
        rd_ready = 1'b0;
        check("unload6_left@lat2", q2.size(), 0);
        check("unload6_left@lat3", q3.size(), 0);
        check("unload6_reads@lat2", reads2, 6);
        check("unload6_reads@lat3", reads3, 6);
        check2("unload6_rdValid", bus2.rdValid, bus3.rdValid, 0);
        check2("unload6_busy",    bus2.busy,    bus3.busy,    0);

        // UNLOAD 8 with rdReady toggling every cycle.
        reads2 = 0;
        reads3 = 0;
        push_expected(8);
        send_cmd(2'b11, 11'd8);
        for (int i = 0; i < 120 && (q2.size() != 0 || q3.size() != 0 || bus2.busy || bus3.busy); i++) begin
            rd_ready = ~rd_ready;
            cyc();
        end
        rd_ready = 1'b0;
        check("unload8_left@lat2", q2.size(), 0);
        check("unload8_left@lat3", q3.size(), 0);
        check("unload8_reads@lat2", reads2, 8);
        check("unload8_reads@lat3", reads3, 8);
        check2("unload8_rdValid",  bus2.rdValid,  bus3.rdValid,  0);
        check2("unload8_cmdReady", bus2.cmdReady, bus3.cmdReady, 1);

        // Zero-length LOAD and reserved op: accepted, no traffic, stay idle.
        send_cmd(2'b01, 11'd0);
        check2("zlen_busy",     bus2.busy,     bus3.busy,     0);
        check2("zlen_cmdReady", bus2.cmdReady, bus3.cmdReady, 1);
        check2("zlen_wrReady",  bus2.wrReady,  bus3.wrReady,  0);
        wr_valid = 1'b1;
        wr_data  = 16'h5555;
        cyc();
        check2("zlen_no_write", bus2.accInstr,  bus3.accInstr,  0);
        check2("zlen_hold",     bus2.accDataIn, bus3.accDataIn, 16'h3333);
        wr_valid = 1'b0;
        send_cmd(2'b00, 11'd4);
        check2("rsvd_busy",  bus2.busy,     bus3.busy,     0);
        check2("rsvd_instr", bus2.accInstr, bus3.accInstr, 0);
        cyc();
        check2("rsvd_stay_idle", bus2.busy, bus3.busy, 0);
`ifdef ACCEL_HOST_LINK_STATS_EN
        check2("stat_in_zlen",  st_in2,  st_in3,  3);
        check2("stat_out_zlen", st_out2, st_out3, 14);
`endif

        // UNLOAD 2 left in the FIFO, then reset in the middle of a LOAD.
        reads2 = 0;
        reads3 = 0;
        push_expected(2);
        send_cmd(2'b11, 11'd2);
        wait_idle(20);
        check2("held_busy",    bus2.busy,    bus3.busy,    0);
        check2("held_rdValid", bus2.rdValid, bus3.rdValid, 1);
        check2("held_head",    bus2.rdData,  bus3.rdData,  16'(16'hA0 + 14));
`ifdef ACCEL_HOST_LINK_STATS_EN
        check2("stat_out_unload2", st_out2, st_out3, 16);
`endif
        send_cmd(2'b01, 11'd4);
        wr_valid = 1'b1;
        wr_data  = 16'h4444;
        cyc();
        check2("midload_w0", bus2.accInstr, bus3.accInstr, 1);
        wr_data = 16'h4545;
        cyc();
        check2("midload_w1_instr", bus2.accInstr,  bus3.accInstr,  1);
        check2("midload_w1_data",  bus2.accDataIn, bus3.accDataIn, 16'h4545);
        rst_n = 1'b0;
        #1;
        check2("rstmid_accInstr",  bus2.accInstr,  bus3.accInstr,  0);
        check2("rstmid_accDataIn", bus2.accDataIn, bus3.accDataIn, 0);
        check2("rstmid_rdValid",   bus2.rdValid,   bus3.rdValid,   0);
        check2("rstmid_busy",      bus2.busy,      bus3.busy,      0);
        check2("rstmid_wrReady",   bus2.wrReady,   bus3.wrReady,   0);
        check2("rstmid_cmdReady",  bus2.cmdReady,  bus3.cmdReady,  0);
`ifdef ACCEL_HOST_LINK_STATS_EN
        check2("rstmid_stat_in",  st_in2,  st_in3,  0);
        check2("rstmid_stat_out", st_out2, st_out3, 0);
`endif
        q2.delete();
        q3.delete();
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        check2("rel_cmdReady_low", bus2.cmdReady, bus3.cmdReady, 0);
        cyc();
        check2("rel_cmdReady_high", bus2.cmdReady, bus3.cmdReady, 1);
        check2("rel_no_instr",      bus2.accInstr, bus3.accInstr, 0);
        check2("rel_rdValid",       bus2.rdValid,  bus3.rdValid,  0);
        cyc();
        check2("rel_still_no_instr", bus2.accInstr, bus3.accInstr, 0);
        wr_valid = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
